// File: rtl/fp16_pkg.sv
// Shared fp16 types for the activation-operator response path.
// Provides operand pair / result record bundles and a few fp16 constants.
package fp16_pkg;

   typedef logic [15:0] fp16_t;

   typedef struct packed {
      fp16_t a;
      fp16_t x;
   } fp16_pair_t;

   typedef struct packed {
      fp16_t a;
      fp16_t x;
      fp16_t y;
   } fp16_rec_t;

   localparam fp16_t FP16_ONE          = 16'h3c00;
   localparam fp16_t FP16_MIN_NEG_NORM = 16'h8400;
   localparam fp16_t FP16_MAX_NEG_NORM = 16'hfbff;

endpackage

// File: rtl/fp16_tag_fifo.sv
// In-order tag FIFO of operand pairs; head is visible combinationally.
// Ports: clk_i, rst_ni (sync), push_i/wdata_i, pop_i/rdata_o,
// empty_o, full_o, count_o (entries held).
module fp16_tag_fifo
   import fp16_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  fp16_pair_t    wdata_i,
   input  logic          pop_i,
   output fp16_pair_t    rdata_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   fp16_pair_t mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/fp16_result_pairer.sv
// Forwards operand pairs to an fp16 operator and rejoins each result
// with its operands as an {a, x, y} record.
// Ports: s_* operand stream in, dut_* operator side, m_* record out,
// inflight/rec_count/orphan_err status.
module fp16_result_pairer
   import fp16_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 32
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [15:0]                  s_x,
   input  logic [15:0]                  s_a,
   output logic                         dut_ivalid,
   input  logic                         dut_iready,
   output logic [15:0]                  dut_datain_x,
   output logic [15:0]                  dut_datain_a,
   input  logic                         dut_ovalid,
   output logic                         dut_oready,
   input  logic [15:0]                  dut_dataout,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [15:0]                  m_a,
   output logic [15:0]                  m_x,
   output logic [15:0]                  m_y,
   output logic [$clog2(DEPTH+1)-1:0]   inflight,
   output logic [CNT_W-1:0]             rec_count,
   output logic                         orphan_err
);

   logic       full, empty;
   logic       accept, ret, good_ret, bad_ret;
   fp16_pair_t tag_in, head;

   fp16_rec_t        rec_q, rec_d;
   logic             m_valid_q, m_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             orphan_q, orphan_d;

   // Credit limit comes from the registered tag count, so a pop
   // frees a slot only from the following cycle.
   assign dut_datain_x = s_x;
   assign dut_datain_a = s_a;
   assign dut_ivalid   = s_valid & ~full;
   assign s_ready      = dut_iready & ~full;
   assign accept       = s_valid & s_ready;

   assign dut_oready = ~m_valid_q | m_ready;
   assign ret        = dut_ovalid & dut_oready;
   assign good_ret   = ret & ~empty;
   assign bad_ret    = ret & empty;

   assign tag_in.a = s_a;
   assign tag_in.x = s_x;

   fp16_tag_fifo #(
      .DEPTH (DEPTH)
   ) u_tags (
      .clk_i   (clock),
      .rst_ni  (resetn),
      .push_i  (accept),
      .wdata_i (tag_in),
      .pop_i   (good_ret),
      .rdata_o (head),
      .empty_o (empty),
      .full_o  (full),
      .count_o (inflight)
   );

   always_comb begin
      rec_d     = rec_q;
      m_valid_d = m_valid_q;
      cnt_d     = cnt_q;
      orphan_d  = orphan_q | bad_ret;
      if (good_ret) begin
         rec_d.a   = head.a;
         rec_d.x   = head.x;
         rec_d.y   = dut_dataout;
         m_valid_d = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
      if (m_valid_q && m_ready && !(&cnt_q))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         rec_q     <= '0;
         m_valid_q <= 1'b0;
         cnt_q     <= '0;
         orphan_q  <= 1'b0;
      end else begin
         rec_q     <= rec_d;
         m_valid_q <= m_valid_d;
         cnt_q     <= cnt_d;
         orphan_q  <= orphan_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_a        = rec_q.a;
   assign m_x        = rec_q.x;
   assign m_y        = rec_q.y;
   assign rec_count  = cnt_q;
   assign orphan_err = orphan_q;

endmodule

// File: tb/tb_fp16_result_pairer.sv
// Randomized bench for fp16_result_pairer with an in-order operator
// model and an accept-order record scoreboard.
module tb_fp16_result_pairer;

   localparam int DEPTH   = 16;
   localparam int CNT_W   = 8;
   localparam int REC_MAX = (1 << CNT_W) - 1;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              resetn = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [15:0]       s_x = '0;
   logic [15:0]       s_a = '0;
   logic              dut_ivalid;
   logic              dut_iready = 1'b1;
   logic [15:0]       dut_datain_x;
   logic [15:0]       dut_datain_a;
   logic              dut_ovalid = 1'b0;
   logic              dut_oready;
   logic [15:0]       dut_dataout = '0;
   logic              m_valid;
   logic              m_ready = 1'b1;
   logic [15:0]       m_a, m_x, m_y;
   logic [4:0]        inflight;
   logic [CNT_W-1:0]  rec_count;
   logic              orphan_err;

   fp16_result_pairer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_x          (s_x),
      .s_a          (s_a),
      .dut_ivalid   (dut_ivalid),
      .dut_iready   (dut_iready),
      .dut_datain_x (dut_datain_x),
      .dut_datain_a (dut_datain_a),
      .dut_ovalid   (dut_ovalid),
      .dut_oready   (dut_oready),
      .dut_dataout  (dut_dataout),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_a          (m_a),
      .m_x          (m_x),
      .m_y          (m_y),
      .inflight     (inflight),
      .rec_count    (rec_count),
      .orphan_err   (orphan_err)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] x;
      int          due;
   } op_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] x;
   } pr_t;

   op_t opq[$];
   pr_t expq[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat = 11;
   int op_allow = -1;
   bit op_manual = 0;
   int ref_inflight = 0;
   int ref_rec = 0;
   bit ref_orphan = 0;
   bit last_acc, last_good, last_rec;

   // Stand-in operator transfer function.
   function automatic logic [15:0] opf(logic [15:0] a, logic [15:0] x);
      return (a ^ {x[6:0], x[15:7]}) + 16'h1357;
   endfunction

   task automatic cycle();
      logic acc, ret, rec;
      logic [15:0] ca, cx;
      @(negedge clock);
      acc = s_valid & s_ready;
      ret = dut_ovalid & dut_oready;
      rec = m_valid & m_ready;
      ca  = s_a;
      cx  = s_x;
      checks++;
      if (s_ready !== (dut_iready && ref_inflight < DEPTH)) begin
         failures++;
         $display("FAIL s_ready got=%b inflight_ref=%0d", s_ready, ref_inflight);
      end
      last_acc  = 0;
      last_good = 0;
      last_rec  = 0;
      if (resetn) begin
         if (rec) begin
            last_rec = 1;
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("FAIL record_extra got a=%h x=%h y=%h required none", m_a, m_x, m_y);
            end else begin
               if (m_a !== expq[0].a || m_x !== expq[0].x ||
                   m_y !== opf(expq[0].a, expq[0].x)) begin
                  failures++;
                  $display("FAIL record got a=%h x=%h y=%h required a=%h x=%h y=%h",
                           m_a, m_x, m_y, expq[0].a, expq[0].x,
                           opf(expq[0].a, expq[0].x));
               end
               void'(expq.pop_front());
            end
            if (ref_rec < REC_MAX) ref_rec++;
         end
         if (ret) begin
            if (ref_inflight > 0) begin
               ref_inflight--;
               last_good = 1;
            end else begin
               ref_orphan = 1;
            end
         end
         if (acc) begin
            ref_inflight++;
            expq.push_back('{ca, cx});
            last_acc = 1;
         end
      end else begin
         expq.delete();
         ref_inflight = 0;
         ref_rec = 0;
         ref_orphan = 0;
      end
      @(posedge clock);
      cyc++;
      #1;
      if (!op_manual) begin
         if (ret && opq.size() > 0) begin
            void'(opq.pop_front());
            if (op_allow > 0) op_allow--;
         end
         if (acc) opq.push_back('{ca, cx, cyc + lat});
         if (opq.size() > 0 && opq[0].due <= cyc && op_allow != 0) begin
            dut_ovalid  = 1'b1;
            dut_dataout = opf(opq[0].a, opq[0].x);
         end else begin
            dut_ovalid  = 1'b0;
            dut_dataout = 16'h0;
         end
      end
      checks++;
      if (inflight !== ref_inflight[4:0]) begin
         failures++;
         $display("FAIL inflight got=%0d required=%0d", inflight, ref_inflight);
      end
      checks++;
      if (orphan_err !== ref_orphan) begin
         failures++;
         $display("FAIL orphan_err got=%b required=%b", orphan_err, ref_orphan);
      end
      checks++;
      if (rec_count !== ref_rec[CNT_W-1:0]) begin
         failures++;
         $display("FAIL rec_count got=%0d required=%0d", rec_count, ref_rec);
      end
   endtask

   task automatic drain();
      s_valid = 0;
      m_ready = 1;
      dut_iready = 1;
      op_allow = -1;
      for (int n = 0; n < 300 && (expq.size() > 0 || m_valid); n++) cycle();
      checks++;
      if (expq.size() != 0 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_timeout got pending=%0d m_valid=%b required 0",
                  expq.size(), m_valid);
      end
   endtask

   task automatic test_reset();
      resetn = 0;
      s_valid = 0;
      cycle();
      cycle();
      checks++;
      if (m_valid !== 0 || m_a !== 0 || m_x !== 0 || m_y !== 0) begin
         failures++;
         $display("FAIL reset_rec got v=%b a=%h x=%h y=%h required 0",
                  m_valid, m_a, m_x, m_y);
      end
      checks++;
      if (inflight !== 0 || rec_count !== 0 || orphan_err !== 0) begin
         failures++;
         $display("FAIL reset_stat got inflight=%0d rec=%0d orphan=%b required 0",
                  inflight, rec_count, orphan_err);
      end
      checks++;
      if (s_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_s_ready got=%b required=1", s_ready);
      end
      resetn = 1;
   endtask

   task automatic test_stream();
      int idx = 0;
      int first = -1;
      int seen = -1;
      lat = 11;
      m_ready = 1;
      s_a = 16'h3c00;
      for (int g = 0; g < 100 && idx < 17; g++) begin
         s_valid = 1;
         s_x = 16'(16'h8400 + idx);
         cycle();
         if (last_acc) begin
            if (first < 0) first = cyc;
            idx++;
         end
         if (m_valid && seen < 0) seen = cyc;
      end
      s_valid = 0;
      for (int g = 0; g < 40 && seen < 0; g++) begin
         cycle();
         if (m_valid) seen = cyc;
      end
      checks++;
      if (seen - first !== 12) begin
         failures++;
         $display("FAIL stream_latency got=%0d required=12", seen - first);
      end
      drain();
      checks++;
      if (rec_count !== 8'd17) begin
         failures++;
         $display("FAIL stream_count got=%0d required=17", rec_count);
      end
   endtask

   task automatic test_credit();
      int acc = 0;
      op_allow = 0;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1;
         s_a = 16'($urandom);
         s_x = 16'($urandom);
         cycle();
         if (last_acc) acc++;
      end
      checks++;
      if (acc !== 16) begin
         failures++;
         $display("FAIL credit_accepted got=%0d required=16", acc);
      end
      checks++;
      if (s_ready !== 0 || dut_ivalid !== 0 || inflight !== 5'd16) begin
         failures++;
         $display("FAIL credit_full got s_ready=%b ivalid=%b inflight=%0d required 0 0 16",
                  s_ready, dut_ivalid, inflight);
      end
      s_valid = 0;
      op_allow = 1;
      cycle();
      cycle();
      checks++;
      if (inflight !== 5'd15 || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL credit_release got inflight=%0d s_ready=%b required 15 1",
                  inflight, s_ready);
      end
      drain();
   endtask

   task automatic test_stall();
      int n = 0;
      int st = 0;
      int sc = 0;
      bit started = 0;
      bit done = 0;
      int rec0 = ref_rec;
      lat = 5;
      for (int g = 0; g < 200 && !(n >= 20 && done); g++) begin
         s_valid = (n < 20);
         s_a = 16'($urandom);
         s_x = 16'($urandom);
         if (!started && m_valid) begin
            started = 1;
            st = 5;
         end
         m_ready = !(st > 0);
         #1;
         if (!m_ready && m_valid) begin
            sc++;
            checks++;
            if (dut_oready !== 1'b0) begin
               failures++;
               $display("FAIL stall_oready got=%b required=0", dut_oready);
            end
         end
         cycle();
         if (last_acc) n++;
         if (st > 0) begin
            st--;
            if (st == 0) done = 1;
         end
      end
      m_ready = 1;
      drain();
      checks++;
      if (sc !== 5) begin
         failures++;
         $display("FAIL stall_cycles got=%0d required=5", sc);
      end
      checks++;
      if (rec_count !== 8'(rec0 + 20)) begin
         failures++;
         $display("FAIL stall_count got=%0d required=%0d", rec_count, rec0 + 20);
      end
   endtask

   task automatic test_simul();
      bit found = 0;
      int pre;
      lat = 3;
      m_ready = 1;
      for (int g = 0; g < 40 && !found; g++) begin
         s_valid = 1;
         s_a = 16'($urandom);
         s_x = 16'($urandom);
         pre = ref_inflight;
         cycle();
         if (last_acc && last_good && last_rec) begin
            found = 1;
            checks++;
            if (inflight !== pre[4:0] || m_valid !== 1'b1) begin
               failures++;
               $display("FAIL simul_state got inflight=%0d v=%b required %0d 1",
                        inflight, m_valid, pre);
            end
            checks++;
            if (m_y !== opf(expq[0].a, expq[0].x)) begin
               failures++;
               $display("FAIL simul_y got=%h required=%h", m_y,
                        opf(expq[0].a, expq[0].x));
            end
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL simul_event got=0 required=1");
      end
      drain();
   endtask

   task automatic test_random();
      lat = $urandom_range(1, 11);
      for (int i = 0; i < 400; i++) begin
         s_valid = ($urandom_range(0, 9) < 7);
         s_a = 16'($urandom);
         s_x = 16'($urandom);
         m_ready = ($urandom_range(0, 9) < 7);
         dut_iready = ($urandom_range(0, 9) < 8);
         cycle();
      end
      drain();
   endtask

   task automatic test_saturate();
      int extra = 0;
      lat = 1;
      m_ready = 1;
      for (int g = 0; g < 1500 && extra < 5; g++) begin
         s_valid = 1;
         s_a = 16'($urandom);
         s_x = 16'($urandom);
         cycle();
         if (ref_rec == REC_MAX && last_rec) extra++;
      end
      checks++;
      if (rec_count !== 8'hff) begin
         failures++;
         $display("FAIL saturate got=%0d required=255", rec_count);
      end
      drain();
   endtask

   task automatic test_orphan();
      op_manual = 1;
      dut_ovalid = 1;
      dut_dataout = 16'hbc00;
      cycle();
      dut_ovalid = 0;
      dut_dataout = 16'h0;
      checks++;
      if (orphan_err !== 1 || m_valid !== 0 || inflight !== 0) begin
         failures++;
         $display("FAIL orphan got err=%b v=%b inflight=%0d required 1 0 0",
                  orphan_err, m_valid, inflight);
      end
      repeat (3) cycle();
      checks++;
      if (orphan_err !== 1'b1) begin
         failures++;
         $display("FAIL orphan_sticky got=%b required=1", orphan_err);
      end
      resetn = 0;
      cycle();
      resetn = 1;
      checks++;
      if (orphan_err !== 1'b0) begin
         failures++;
         $display("FAIL orphan_clear got=%b required=0", orphan_err);
      end
      op_manual = 0;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      lat = 11;
      m_ready = 0;
      for (int g = 0; g < 40 && n < 9; g++) begin
         s_valid = 1;
         s_a = 16'($urandom);
         s_x = 16'($urandom);
         cycle();
         if (last_acc) n++;
      end
      s_valid = 0;
      for (int g = 0; g < 40 && !m_valid; g++) cycle();
      checks++;
      if (m_valid !== 1'b1 || inflight !== 5'd8) begin
         failures++;
         $display("FAIL mid_setup got v=%b inflight=%0d required 1 8",
                  m_valid, inflight);
      end
      resetn = 0;
      cycle();
      resetn = 1;
      checks++;
      if (m_valid !== 0 || inflight !== 0 || rec_count !== 0 ||
          orphan_err !== 0 || m_y !== 0) begin
         failures++;
         $display("FAIL mid_reset got v=%b inflight=%0d rec=%0d err=%b y=%h required 0",
                  m_valid, inflight, rec_count, orphan_err, m_y);
      end
      cycle();
      checks++;
      if (orphan_err !== 1'b1) begin
         failures++;
         $display("FAIL mid_orphan got=%b required=1", orphan_err);
      end
      m_ready = 1;
      for (int g = 0; g < 100 && opq.size() > 0; g++) cycle();
      resetn = 0;
      cycle();
      resetn = 1;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_credit();
      test_stall();
      test_simul();
      test_random();
      test_saturate();
      test_orphan();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp16_result_pairer.md
Name: fp16_result_pairer

Overview:
Response-side companion for the fp16 activation operators (expm1alpha_fp16_top and siblings). It accepts operand pairs from a stimulus or producer stream and forwards them to the operator. It records each accepted pair in an in-order tag FIFO, then rejoins every operator result with the exact operands that produced it. Downstream consumers (result writer, golden-model checker) receive self-describing {a, x, y} records, so no latency-offset arithmetic is needed, and backpressure is honoured end to end.

Parameters:
DEPTH, 16, max operands in flight inside the operator; must be >= operator latency (A10 11, S10 9) and a power of two
CNT_W, 32, width of the record counter

Ports:
clock  in  1  single clock domain
resetn  in  1  synchronous, active-low reset
s_valid  in  1  operand pair valid
s_ready  out  1  pairer can accept operand pair
s_x  in  16  fp16 operand x
s_a  in  16  fp16 operand alpha
dut_ivalid  out  1  to operator ivalid
dut_iready  in  1  from operator iready
dut_datain_x  out  16  to operator datain_x
dut_datain_a  out  16  to operator datain_a
dut_ovalid  in  1  from operator ovalid
dut_oready  out  1  to operator oready
dut_dataout  in  16  from operator dataout
m_valid  out  1  record valid
m_ready  in  1  consumer accepts record
m_a  out  16  alpha of record
m_x  out  16  x of record
m_y  out  16  operator result for (a, x)
inflight  out  $clog2(DEPTH+1)  operands accepted but not yet returned
rec_count  out  CNT_W  records delivered (m_valid & m_ready), saturating
orphan_err  out  1  sticky: result arrived with empty tag FIFO

Behaviour:
- Reset (resetn=0 at posedge): m_valid=0, m_a/m_x/m_y=0, inflight=0, rec_count=0, orphan_err=0, FIFO pointers=0. Reset mid-operation discards all tags and any held record; an operator result arriving in the first cycle after reset sets orphan_err.
- Forward path is combinational: dut_datain_x=s_x, dut_datain_a=s_a, dut_ivalid=s_valid & (inflight<DEPTH), s_ready=dut_iready & (inflight<DEPTH).
- accept = s_valid & s_ready. On accept, push {s_a, s_x} into the tag FIFO.
- Output register is single-entry. dut_oready = ~m_valid | m_ready, so full throughput is sustained with no bubble.
- ret = dut_ovalid & dut_oready.
  - On ret with FIFO non-empty: pop the tag, load m_a/m_x from the tag and m_y=dut_dataout, and set m_valid=1 on the next cycle. Latency from result to record is 1 cycle.
  - On ret with FIFO empty: set orphan_err=1 (sticky until reset), load nothing, leave inflight unchanged.
- m_valid clears when m_valid & m_ready and no new ret occurs in the same cycle. If both happen, the register reloads and m_valid stays 1.
- inflight: +1 on accept only, -1 on a good ret only, unchanged when both occur. Never exceeds DEPTH: at inflight==DEPTH, s_ready=0 and dut_ivalid=0.
- rec_count increments on m_valid & m_ready and saturates at all-ones.
- FIFO full and empty are derived from inflight. Pointers wrap modulo DEPTH. Push and pop in the same cycle are legal, including when the FIFO is full (a pop makes room only from the next cycle, because s_ready uses the registered inflight).
- Ordering: records emerge in accept order. The operator is in-order and returns exactly one result per accepted input.

Decomposition:
- Shared package fp16_pkg: typedef fp16_t (logic [15:0]); struct fp16_pair_t {a, x}; struct fp16_rec_t {a, x, y}; constants FP16_ONE=16'h3c00, FP16_MIN_NEG_NORM=16'h8400, FP16_MAX_NEG_NORM=16'hfbff.
- Sub-module: fp16_tag_fifo, a synchronous FIFO of fp16_pair_t with DEPTH entries, push/pop/empty/full, no read latency (head visible combinationally).

Test Plan:
- Streaming at latency 11, m_ready=1: feed a=3c00 with x=8400..8410 -> 17 records in order, with m_x matching each input and m_y equal to the operator output. The first m_valid appears 12 cycles after the first accept; rec_count ends at 17.
- Credit limit: operator with iready=1 and ovalid held 0, 20 pairs offered -> exactly 16 accepted, then s_ready=0 with inflight=16. Releasing one result gives inflight=15 and s_ready=1 the next cycle.
- Downstream stall: m_ready=0 for 5 cycles during streaming -> dut_oready=0 while m_valid=1; no record is lost or duplicated; rec_count equals the input count after drain.
- Simultaneous events: accept, good ret and record take all in the same cycle -> inflight unchanged, m_valid stays 1, new m_y loaded.
- Orphan: dut_ovalid=1 with dut_dataout=bc00 and nothing accepted -> orphan_err=1, m_valid=0, inflight=0. orphan_err stays 1 until resetn=0.
- Reset mid-flight: 8 in flight, held record, resetn=0 for 1 cycle -> m_valid=0, inflight=0, rec_count=0, and the FIFO is empty (the next result raises orphan_err).
